// File: rtl/decode_pkg.sv
// decode_pkg: default widths and shared types for the decode register file.
package decode_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 2;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
  typedef logic [CNT_W-1:0]  pend_cnt_t;
endpackage

// File: rtl/sb_pend_counter.sv
// sb_pend_counter: saturating pending-write counter; inc and dec together cancel out.
module sb_pend_counter import decode_pkg::*; #(
  parameter int CNT_W = decode_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             sat,
  output logic             underflow
);
  assign zero      = cnt == '0;
  assign sat       = &cnt;
  assign underflow = dec && !inc && zero;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (inc && !dec && !sat) cnt <= cnt + 1'b1;
    else if (dec && !inc && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/decode_regfile_sb.sv
// decode_regfile_sb: decode register file with write-through bypass and RAW scoreboard stall.
// Define RF_ZERO_REG_EN to hardwire r0 to zero.
module decode_regfile_sb import decode_pkg::*; #(
  parameter int DATA_W = decode_pkg::DATA_W,
  parameter int ADDR_W = decode_pkg::ADDR_W,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = decode_pkg::CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue_valid,
  input  logic                     issue_wr,
  input  logic [ADDR_W-1:0]        issue_dest,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     stall,
  output logic                     issue_ack,
  input  logic                     wb_en,
  input  logic                     wb_cancel,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  output logic                     err
);
  localparam int NREG = 1 << ADDR_W;
`ifdef RF_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  pend [NREG];
  logic [NREG-1:0]   inc, dec, zero, sat, ufl;
  logic [NUM_RD-1:0] haz;
  logic              hold, wr_ok;
  assign hold      = |haz || (issue_wr && sat[issue_dest]);
  assign stall     = issue_valid && hold;
  assign issue_ack = issue_valid && rst && !hold;
  assign wr_ok     = wb_en && !(ZR && wb_addr == '0);
  for (genvar r = 0; r < NREG; r++) begin : g_reg
    assign inc[r] = !(ZR && r == 0) && issue_ack && issue_wr && issue_dest == ADDR_W'(r);
    assign dec[r] = !(ZR && r == 0) && (wb_en || wb_cancel) && wb_addr == ADDR_W'(r);
    sb_pend_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk(clk), .rst(rst), .inc(inc[r]), .dec(dec[r]),
      .cnt(pend[r]), .zero(zero[r]), .sat(sat[r]), .underflow(ufl[r])
    );
  end
  // a single outstanding write retiring this cycle is satisfied by the bypass
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              byp;
    assign a   = rd_addr[i*ADDR_W +: ADDR_W];
    assign byp = wb_en && wb_addr == a;
    assign rd_data[i*DATA_W +: DATA_W] = (ZR && a == '0) ? '0 : byp ? wb_data : regs[a];
    assign haz[i] = rd_en[i] && !zero[a] && !(pend[a] == CNT_W'(1) && byp);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int k = 0; k < NREG; k++) regs[k] <= '0;
    else if (wr_ok) regs[wb_addr] <= wb_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) err <= 1'b0;
    else if ((wb_en && wb_cancel) || |ufl) err <= 1'b1;
endmodule

// File: tb/tb_decode_regfile_sb.sv
// tb_decode_regfile_sb: directed vector table, reset/zero-register sequences, then random run vs. a reference model.
module tb_decode_regfile_sb;
  import decode_pkg::*;
`ifdef RF_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif
  localparam int MAXP = (1 << CNT_W) - 1;
  logic clk = 1'b0, rst = 1'b0;
  logic iv, iw, we, wc, stall, ack, err;
  logic [2:0] id, wa;
  logic [1:0] re;
  logic [5:0] ra;
  logic [15:0] wd;
  logic [31:0] rd;
  int total = 0, bad = 0;
  logic [15:0] mregs [8];
  int mpend [8];
  logic merr;
  always #5 clk = ~clk;
  decode_regfile_sb dut (
    .clk(clk), .rst(rst), .issue_valid(iv), .issue_wr(iw), .issue_dest(id),
    .rd_en(re), .rd_addr(ra), .rd_data(rd), .stall(stall), .issue_ack(ack),
    .wb_en(we), .wb_cancel(wc), .wb_addr(wa), .wb_data(wd), .err(err)
  );
  typedef struct {
    logic iv, iw; logic [2:0] id; logic [1:0] re; logic [2:0] a0, a1;
    logic we, wc; logic [2:0] wa; logic [15:0] wd;
    logic es, ea, ee; logic [1:0] m; logic [15:0] e0, e1;
  } vec_t;
  vec_t tbl [21];
  function automatic vec_t mk(int v_iv, int v_iw, int v_id, int v_re, int v_a0, int v_a1,
                              int v_we, int v_wc, int v_wa, int v_wd,
                              int v_es, int v_ea, int v_ee, int v_m, int v_e0, int v_e1);
    vec_t v;
    v.iv = 1'(v_iv); v.iw = 1'(v_iw); v.id = 3'(v_id); v.re = 2'(v_re);
    v.a0 = 3'(v_a0); v.a1 = 3'(v_a1); v.we = 1'(v_we); v.wc = 1'(v_wc);
    v.wa = 3'(v_wa); v.wd = 16'(v_wd); v.es = 1'(v_es); v.ea = 1'(v_ea);
    v.ee = 1'(v_ee); v.m = 2'(v_m); v.e0 = 16'(v_e0); v.e1 = 16'(v_e1);
    return v;
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", n, act, exp, $time);
    end
  endtask
  task automatic model_reset;
    for (int r = 0; r < 8; r++) begin mregs[r] = '0; mpend[r] = 0; end
    merr = 1'b0;
  endtask
  function automatic logic m_stall();
    logic h = iw && mpend[id] == MAXP;
    for (int p = 0; p < 2; p++) begin
      int a = int'(ra[p*3 +: 3]);
      if (re[p] && mpend[a] != 0 && !(mpend[a] == 1 && we && int'(wa) == a)) h = 1'b1;
    end
    return iv && h;
  endfunction
  function automatic logic [15:0] m_rd(int p);
    int a = int'(ra[p*3 +: 3]);
    if (!rst || (ZR && a == 0)) return 16'h0;
    if (we && int'(wa) == a) return wd;
    return mregs[a];
  endfunction
  task automatic tick;
    logic mack = rst && iv && !m_stall();
    int np [8];
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 8; r++) np[r] = mpend[r];
      if (mack && iw && !(ZR && id == 0)) np[id]++;
      if ((we || wc) && !(ZR && wa == 0)) np[wa]--;
      for (int r = 0; r < 8; r++) begin
        if (np[r] < 0) begin np[r] = 0; merr = 1'b1; end
        mpend[r] = np[r];
      end
      if (we && wc) merr = 1'b1;
      if (we && !(ZR && wa == 0)) mregs[wa] = wd;
    end
    #1;
  endtask
  initial begin
    iv = 1; iw = 1; id = 3; re = 2'b11; ra = 6'o35; we = 0; wc = 0; wa = 0; wd = 0;
    model_reset();
    #2;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rd", rd, 0);
    repeat (2) @(posedge clk);
    #1; iv = 0; rst = 1; #1;
    tbl[0]  = mk(1,1,3,0,0,0, 0,0,0,0,      0,1,0,0,0,0);
    tbl[1]  = mk(0,0,0,1,3,0, 1,0,3,'hBEEF, 0,0,0,1,'hBEEF,0);
    tbl[2]  = mk(1,0,0,1,3,0, 0,0,0,0,      0,1,0,1,'hBEEF,0);
    tbl[3]  = mk(1,1,5,0,0,0, 0,0,0,0,      0,1,0,0,0,0);
    tbl[4]  = mk(1,1,2,2,0,5, 1,0,5,'h1234, 0,1,0,2,0,'h1234);
    tbl[5]  = mk(1,0,0,1,2,0, 0,0,0,0,      1,0,0,0,0,0);
    tbl[6]  = mk(1,0,0,1,2,0, 1,0,2,'h00AA, 0,1,0,1,'h00AA,0);
    tbl[7]  = mk(0,0,0,0,5,2, 0,0,0,0,      0,0,0,3,'h1234,'h00AA);
    tbl[8]  = mk(1,1,4,0,0,0, 0,0,0,0,      0,1,0,0,0,0);
    tbl[9]  = mk(1,1,4,0,0,0, 0,0,0,0,      0,1,0,0,0,0);
    tbl[10] = mk(1,1,4,0,0,0, 0,0,0,0,      0,1,0,0,0,0);
    tbl[11] = mk(1,1,4,0,0,0, 0,0,0,0,      1,0,0,0,0,0);
    tbl[12] = mk(1,1,4,0,0,0, 0,1,4,0,      1,0,0,0,0,0);
    tbl[13] = mk(1,1,4,0,0,0, 0,0,0,0,      0,1,0,0,0,0);
    tbl[14] = mk(1,0,0,1,4,0, 0,0,0,0,      1,0,0,0,0,0);
    tbl[15] = mk(1,1,6,0,0,0, 0,0,0,0,      0,1,0,0,0,0);
    tbl[16] = mk(1,1,6,0,0,0, 1,0,6,'h6666, 0,1,0,0,0,0);
    tbl[17] = mk(1,0,0,1,6,0, 0,0,0,0,      1,0,0,1,'h6666,0);
    tbl[18] = mk(0,0,0,0,0,0, 0,1,1,0,      0,0,0,0,0,0);
    tbl[19] = mk(0,0,0,0,0,0, 0,0,0,0,      0,0,1,0,0,0);
    tbl[20] = mk(0,0,0,0,0,0, 0,0,0,0,      0,0,1,0,0,0);
    for (int k = 0; k < 21; k++) begin
      iv = tbl[k].iv; iw = tbl[k].iw; id = tbl[k].id; re = tbl[k].re;
      ra = {tbl[k].a1, tbl[k].a0}; we = tbl[k].we; wc = tbl[k].wc;
      wa = tbl[k].wa; wd = tbl[k].wd;
      #1;
      chk($sformatf("vec%0d_stall", k), 32'(stall), 32'(tbl[k].es));
      chk($sformatf("vec%0d_ack", k), 32'(ack), 32'(tbl[k].ea));
      chk($sformatf("vec%0d_err", k), 32'(err), 32'(tbl[k].ee));
      if (tbl[k].m[0]) chk($sformatf("vec%0d_rd0", k), 32'(rd[15:0]), 32'(tbl[k].e0));
      if (tbl[k].m[1]) chk($sformatf("vec%0d_rd1", k), 32'(rd[31:16]), 32'(tbl[k].e1));
      tick();
    end
    iv = 1; iw = 0; re = 2'b01; ra = 6'o05; we = 0; wc = 0;
    rst = 0; model_reset();
    #1;
    chk("arst_err", 32'(err), 0);
    chk("arst_stall", 32'(stall), 0);
    chk("arst_ack", 32'(ack), 0);
    chk("arst_rd0", 32'(rd[15:0]), 0);
    tick();
    iv = 0; rst = 1; #1;
`ifdef RF_ZERO_REG_EN
    iv = 1; iw = 0; re = 2'b11; ra = 6'o00; we = 1; wa = 0; wd = 16'hFFFF;
    #1;
    chk("zr_nobyp", 32'(rd), 0);
    chk("zr_ack", 32'(ack), 1);
    tick();
    we = 0; #1;
    chk("zr_rd", 32'(rd), 0);
    chk("zr_stall", 32'(stall), 0);
    chk("zr_err", 32'(err), 0);
`endif
    for (int c = 0; c < 600; c++) begin
      int cand [$];
      if (!(iv && stall)) begin
        iv = 1'($urandom_range(0, 3) != 0); iw = 1'($urandom); id = 3'($urandom);
        re = 2'($urandom); ra = 6'($urandom);
      end
      for (int r = 0; r < 8; r++) if (mpend[r] > 0) cand.push_back(r);
      we = 0; wc = 0; wd = 16'($urandom); wa = 3'($urandom);
      if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
        wa = 3'(cand[$urandom_range(0, cand.size() - 1)]);
        if ($urandom_range(0, 3) == 0) wc = 1; else we = 1;
      end
      #1;
      chk("rnd_stall", 32'(stall), 32'(m_stall()));
      chk("rnd_ack", 32'(ack), 32'(iv && !m_stall()));
      chk("rnd_rd0", 32'(rd[15:0]), 32'(m_rd(0)));
      chk("rnd_rd1", 32'(rd[31:16]), 32'(m_rd(1)));
      chk("rnd_err", 32'(err), 32'(merr));
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
